// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction descriptors into the 32-bit
// SimpleRISC format and writes them to consecutive imem words through a
// 2-entry output FIFO.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               (re)initialise and enter RUN; wins over accept/pop
//   in_valid/in_ready   descriptor handshake
//   in_op .. in_last    descriptor fields
//   mem_wr_en/mem_ready imem write handshake; head of FIFO drives mem_data
//   mem_addr/mem_data   write address (BASE_ADDR + count) and encoded word
//   busy/done           RUN or DRAIN / DONE
//   err_illegal         sticky, illegal opcode consumed
//   err_full            sticky, imem capacity reached before in_last
//   count               words written since start
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic              in_imm,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [17:0]       in_imm18,
  input  logic [26:0]       in_offset,
  input  logic              in_last,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Capacity (2^ADDR_W) and capacity-1, sized to hold count + occupancy.
  localparam logic [ADDR_W+1:0] DepthW  = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W+1:0] DepthM1 = {2'b00, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        occ_q, occ_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [31:0]       buf_q [2];
  logic              err_illegal_q, err_illegal_d;
  logic              err_full_q, err_full_d;

  logic [ADDR_W+1:0] total;
  logic              illegal, accept, push, pop, full_hit;
  logic [31:0]       enc;

  // Words committed or in flight; bounded by capacity.
  assign total    = {1'b0, count_q} + {{ADDR_W{1'b0}}, occ_q};
  assign illegal  = (in_op > 5'b10101);
  assign accept   = in_valid && in_ready && !start;
  assign push     = accept && !illegal;
  assign pop      = (occ_q != 2'd0) && mem_ready && !start;
  // Only a push can grow total, so the last free slot is taken by this push.
  assign full_hit = (state_q == StRun) && push && !in_last && (total == DepthM1);

  always_comb begin
    enc = '0;
    case (in_op)
      5'b10000, 5'b10001, 5'b10010, 5'b10011: enc = {in_op, in_offset};
      5'b01101, 5'b10100, 5'b10101:           enc = {in_op, 27'b0};
      default: enc = {in_op, in_imm, in_rd, in_rs1, in_imm ? in_imm18 : {in_rs2, 14'b0}};
    endcase
  end

  // FIFO / counter / flag next state.
  always_comb begin
    count_d       = count_q;
    occ_d         = occ_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    err_illegal_d = err_illegal_q;
    err_full_d    = err_full_q;
    if (start) begin
      count_d       = '0;
      occ_d         = '0;
      rd_ptr_d      = 1'b0;
      wr_ptr_d      = 1'b0;
      err_illegal_d = 1'b0;
      err_full_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        count_d  = count_q + {{ADDR_W{1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
      if (accept && illegal) err_illegal_d = 1'b1;
      if (full_hit)          err_full_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
      buf_q[0]      <= '0;
      buf_q[1]      <= '0;
    end else begin
      count_q       <= count_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
      if (push) buf_q[wr_ptr_q] <= enc;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StRun: begin
          if ((accept && in_last) || full_hit) state_d = StDrain;
        end
        // Leave as the final pop happens so done rises the next cycle.
        StDrain: if (occ_d == 2'd0) state_d = StDone;
        StDone:  state_d = StDone;
      endcase
    end
  end

  // FSM / datapath outputs, all from registered state.
  always_comb begin
    in_ready    = (state_q == StRun) && (occ_q != 2'd2) && (total < DepthW);
    busy        = (state_q == StRun) || (state_q == StDrain);
    done        = (state_q == StDone);
    mem_wr_en   = (occ_q != 2'd0);
    mem_data    = mem_wr_en ? buf_q[rd_ptr_q] : 32'h0;
    mem_addr    = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
    err_illegal = err_illegal_q;
    err_full    = err_full_q;
    count       = count_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk, rst, mem_ready;
  logic        start_b, valid_b, start_s, valid_s;
  logic [4:0]  in_op;
  logic        in_imm, in_last;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic [17:0] in_imm18;
  logic [26:0] in_offset;

  logic        b_ready, b_wr_en, b_busy, b_done, b_eill, b_efull;
  logic [9:0]  b_addr_o;
  logic [31:0] b_data;
  logic [10:0] b_count;
  logic        s_ready, s_wr_en, s_busy, s_done, s_eill, s_efull;
  logic [1:0]  s_addr_o;
  logic [31:0] s_data;
  logic [2:0]  s_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int s_writes = 0;
  int wr_cyc[$];
  logic [41:0] exp_b[$];
  logic [33:0] exp_s[$];
  logic [9:0]  b_addr;
  logic [1:0]  s_addr;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_ready(b_ready),
    .in_op(in_op), .in_imm(in_imm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm18(in_imm18), .in_offset(in_offset), .in_last(in_last),
    .mem_wr_en(b_wr_en), .mem_ready(mem_ready), .mem_addr(b_addr_o), .mem_data(b_data),
    .busy(b_busy), .done(b_done), .err_illegal(b_eill), .err_full(b_efull), .count(b_count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(valid_s), .in_ready(s_ready),
    .in_op(in_op), .in_imm(in_imm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm18(in_imm18), .in_offset(in_offset), .in_last(in_last),
    .mem_wr_en(s_wr_en), .mem_ready(mem_ready), .mem_addr(s_addr_o), .mem_data(s_data),
    .busy(s_busy), .done(s_done), .err_illegal(s_eill), .err_full(s_efull), .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference encoder written from the opcode table.
  function automatic logic [31:0] model(input logic [4:0] op, input logic imm,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2, input logic [17:0] i18,
                                        input logic [26:0] off);
    logic [31:0] r;
    r = 32'(op) << 27;
    if (op >= 5'd16 && op <= 5'd19) begin
      r = r | 32'(off);
    end else if (!(op == 5'd13 || op == 5'd20 || op == 5'd21)) begin
      r = r | (32'(imm) << 26) | (32'(rd) << 22) | (32'(rs1) << 18);
      r = r | (imm ? 32'(i18) : (32'(rs2) << 14));
    end
    return r;
  endfunction

  // Scoreboard check of every completed write on the main instance.
  always @(negedge clk) begin
    if (!rst && !start_b && b_wr_en && mem_ready) begin
      wr_cyc.push_back(cyc);
      n_vec++;
      assert (exp_b.size() != 0) else begin
        n_err++;
        $error("FAIL b_unexpected_write: observed addr %0h data %0h expected none",
               b_addr_o, b_data);
      end
      if (exp_b.size() != 0) chk("b_write", {b_addr_o, b_data}, exp_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && !start_s && s_wr_en && mem_ready) begin
      s_writes++;
      n_vec++;
      assert (exp_s.size() != 0) else begin
        n_err++;
        $error("FAIL s_unexpected_write: observed addr %0h data %0h expected none",
               s_addr_o, s_data);
      end
      if (exp_s.size() != 0) chk("s_write", {s_addr_o, s_data}, exp_s.pop_front());
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_b(input logic [4:0] op, input logic imm, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [17:0] i18, input logic [26:0] off,
                        input logic last, input logic [31:0] expd);
    int n;
    in_op = op; in_imm = imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm18 = i18; in_offset = off; in_last = last;
    valid_b = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_b_ready", 64'(b_ready), 64'd1);
    if (b_ready && op <= 5'd21) begin
      exp_b.push_back({b_addr, expd});
      b_addr++;
    end
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  task automatic start_pulse_b();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    b_addr = '0;
  endtask

  task automatic wait_done_b(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!b_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(b_done), 64'd1);
  endtask

  logic [31:0] e1, e2, e3, e4;
  int acc, n;

  initial begin
    rst = 1'b1; mem_ready = 1'b1;
    start_b = 1'b0; valid_b = 1'b0; start_s = 1'b0; valid_s = 1'b0;
    in_op = '0; in_imm = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm18 = '0; in_offset = '0; in_last = 1'b0;
    b_addr = '0; s_addr = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(b_ready), 64'd0);
    chk("rst_wr_en", 64'(b_wr_en), 64'd0);
    chk("rst_addr", 64'(b_addr_o), 64'd0);
    chk("rst_data", 64'(b_data), 64'd0);
    chk("rst_flags", {b_busy, b_done, b_eill, b_efull}, 64'd0);
    chk("rst_count", 64'(b_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Register form
    start_pulse_b();
    @(negedge clk);
    chk("t1_busy", 64'(b_busy), 64'd1);
    @(posedge clk); #1;
    send_b(5'd0, 1'b0, 4'd1, 4'd3, 4'd3, 18'h0, 27'h0, 1'b1, 32'h004CC000);
    @(negedge clk);
    chk("t1_wr_en", 64'(b_wr_en), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_done", 64'(b_done), 64'd1);
    chk("t1_count", 64'(b_count), 64'd1);
    @(posedge clk); #1;

    // Immediate, branch, ret back-to-back
    start_pulse_b();
    wr_cyc.delete();
    send_b(5'd9, 1'b1, 4'd5, 4'd0, 4'd0, 18'h0001F, 27'h0, 1'b0, 32'h4D40001F);
    send_b(5'd18, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h10, 1'b0, 32'h90000010);
    send_b(5'd20, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0, 1'b1, 32'hA0000000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_done", 64'(b_done), 64'd1);
    chk("t2_count", 64'(b_count), 64'd3);
    chk("t2_nwrites", 64'(wr_cyc.size()), 64'd3);
    if (wr_cyc.size() == 3) chk("t2_back_to_back", 64'(wr_cyc[2] - wr_cyc[0]), 64'd2);
    @(posedge clk); #1;

    // Illegal opcode between two legal descriptors
    start_pulse_b();
    send_b(5'd1, 1'b1, 4'd7, 4'd8, 4'd0, 18'h3FFFF, 27'h0, 1'b0,
           model(5'd1, 1'b1, 4'd7, 4'd8, 4'd0, 18'h3FFFF, 27'h0));
    send_b(5'b11000, 1'b0, 4'd1, 4'd1, 4'd1, 18'h1, 27'h1, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_err_illegal", 64'(b_eill), 64'd1);
    @(posedge clk); #1;
    send_b(5'd2, 1'b0, 4'd9, 4'd10, 4'd11, 18'h0, 27'h0, 1'b1,
           model(5'd2, 1'b0, 4'd9, 4'd10, 4'd11, 18'h0, 27'h0));
    wait_done_b("t3_done");
    chk("t3_count", 64'(b_count), 64'd2);
    chk("t3_err_illegal_held", 64'(b_eill), 64'd1);
    @(posedge clk); #1;

    // Backpressure
    e1 = model(5'd1, 1'b1, 4'd2, 4'd3, 4'd0, 18'h2ABCD, 27'h0);
    e2 = model(5'd5, 1'b0, 4'd4, 4'd5, 4'd6, 18'h0, 27'h0);
    e3 = model(5'd16, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h5A5A5A5);
    e4 = model(5'd13, 1'b1, 4'd15, 4'd15, 4'd15, 18'h3FFFF, 27'h7FFFFFF);
    start_pulse_b();
    mem_ready = 1'b0;
    fork
      begin
        send_b(5'd1, 1'b1, 4'd2, 4'd3, 4'd0, 18'h2ABCD, 27'h0, 1'b0, e1);
        send_b(5'd5, 1'b0, 4'd4, 4'd5, 4'd6, 18'h0, 27'h0, 1'b0, e2);
        send_b(5'd16, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h5A5A5A5, 1'b0, e3);
        send_b(5'd13, 1'b1, 4'd15, 4'd15, 4'd15, 18'h3FFFF, 27'h7FFFFFF, 1'b1, e4);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("t4_ready_low", 64'(b_ready), 64'd0);
          chk("t4_hold", {b_wr_en, b_addr_o, b_data}, {1'b1, 10'd0, e1});
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
      end
    join
    wait_done_b("t4_done");
    chk("t4_count", 64'(b_count), 64'd4);
    @(posedge clk); #1;

    // Capacity on the 4-word instance
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    s_addr = '0; s_writes = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_op = 5'd9; in_imm = 1'b1; in_rd = 4'(i); in_rs1 = 4'd1; in_rs2 = 4'd0;
      in_imm18 = 18'(i + 100); in_offset = '0; in_last = 1'b0;
      valid_s = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 8) begin
        @(negedge clk);
        n++;
      end
      if (s_ready) begin
        exp_s.push_back({s_addr, model(5'd9, 1'b1, 4'(i), 4'd1, 4'd0, 18'(i + 100), 27'h0)});
        s_addr++;
        acc++;
      end
      @(posedge clk); #1;
      valid_s = 1'b0;
    end
    @(negedge clk);
    chk("t5_accepts", 64'(acc), 64'd4);
    chk("t5_writes", 64'(s_writes), 64'd4);
    chk("t5_err_full", 64'(s_efull), 64'd1);
    chk("t5_done", 64'(s_done), 64'd1);
    chk("t5_count", 64'(s_count), 64'd4);
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    @(negedge clk);
    chk("t5_restart", {s_count, s_efull, s_eill, s_busy, s_done}, {3'd0, 4'b0010});
    @(posedge clk); #1;

    // Reset with two words buffered
    start_pulse_b();
    mem_ready = 1'b0;
    send_b(5'd3, 1'b0, 4'd1, 4'd2, 4'd3, 18'h0, 27'h0, 1'b0,
           model(5'd3, 1'b0, 4'd1, 4'd2, 4'd3, 18'h0, 27'h0));
    send_b(5'd4, 1'b1, 4'd6, 4'd7, 4'd0, 18'h12345, 27'h0, 1'b0,
           model(5'd4, 1'b1, 4'd6, 4'd7, 4'd0, 18'h12345, 27'h0));
    @(negedge clk);
    chk("t6_buffered", 64'(b_wr_en), 64'd1);
    rst = 1'b1;
    exp_b.delete();
    #1;
    chk("t6_rst_wr_en", 64'(b_wr_en), 64'd0);
    chk("t6_rst_outs", {b_ready, b_busy, b_done, b_eill, b_efull, b_count, b_addr_o},
        64'd0);
    chk("t6_rst_data", 64'(b_data), 64'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_write", 64'(b_wr_en), 64'd0);
    end
    @(posedge clk); #1;
    start_pulse_b();
    send_b(5'd21, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0, 1'b1, 32'hA8000000);
    wait_done_b("t6_done");
    chk("t6_count", 64'(b_count), 64'd1);

    @(posedge clk); #1;
    chk("end_b_queue_empty", 64'(exp_b.size()), 64'd0);
    chk("end_s_queue_empty", 64'(exp_s.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
